// File: rtl/fifo_uart_tx.sv
// FIFO read-side 8N1 UART serialiser: pops one byte per frame; o_rd_en 1 cycle after idle+non-empty, start bit 2 cycles later.
// Backpressure: pops only from IDLE while i_enable is high; each byte occupies 10*CLKS_PER_BIT+3 cycles.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_en,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  rd_en_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  // Outputs are registered alongside the state so each one reflects the state it belongs to.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_enable && !i_fifo_empty) begin
            state_q <= POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP: begin
          state_q <= LOAD;
        end
        LOAD: begin
          state_q <= START;
          shift_q <= i_rd_data;
          bit_q   <= '0;
          baud_q  <= '0;
          tx_q    <= 1'b0;
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_q   <= bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_en   = rd_en_q;
  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds two instances (4 and 2 clocks per bit); a line decoder checks frames against a queue.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic       rst_n;
  logic       en_a, en_b, empty_a, empty_b;
  logic [7:0] data_a, data_b;
  logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8)) dut_a (
    .rd_clk(rd_clk), .rd_rst_n(rst_n), .i_enable(en_a), .i_fifo_empty(empty_a),
    .i_rd_data(data_a), .o_rd_en(rd_a), .o_tx(tx_a), .o_busy(busy_a), .o_tx_done(done_a));

  fifo_uart_tx #(.CLKS_PER_BIT(2), .DATA_WIDTH(8)) dut_b (
    .rd_clk(rd_clk), .rd_rst_n(rst_n), .i_enable(en_b), .i_fifo_empty(empty_b),
    .i_rd_data(data_b), .o_rd_en(rd_b), .o_tx(tx_b), .o_busy(busy_b), .o_tx_done(done_b));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge rd_clk) cyc <= cyc + 1;

  logic [7:0] fifo_a[$], fifo_b[$], sb_a[$], sb_b[$];
  int         ph[2] = '{0, 0};
  int         k[2] = '{0, 0};
  int         bitn[2] = '{0, 0};
  int         last_rd[2] = '{-100, -100};
  int         done_cnt[2] = '{0, 0};
  int         pop_cnt[2] = '{0, 0};
  logic [7:0] acc[2];
  bit         e_start[2], e_bit[2], e_stop[2], e_done[2];
  bit         hold[2] = '{0, 0};
  bit         prev_rd[2] = '{0, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  function automatic logic get_tx(input int d);   return (d == 0) ? tx_a : tx_b;     endfunction
  function automatic logic get_rd(input int d);   return (d == 0) ? rd_a : rd_b;     endfunction
  function automatic logic get_done(input int d); return (d == 0) ? done_a : done_b; endfunction

  // Stimulus: byte enters the FIFO model and its expected line decode enters the scoreboard.
  task automatic send(input int d, input logic [7:0] b);
    if (d == 0) begin fifo_a.push_back(b); sb_a.push_back(b); empty_a = 1'b0; end
    else        begin fifo_b.push_back(b); sb_b.push_back(b); empty_b = 1'b0; end
  endtask

  // FIFO model: data valid from the pop cycle through the following cycle, garbage otherwise.
  task automatic model_step(input int d);
    logic rd;
    logic [7:0] v;
    rd = get_rd(d);
    if (rd) begin
      chk($sformatf("rd_en_one_cycle[%0d]", d), longint'(prev_rd[d]), 0);
      pop_cnt[d]++;
      last_rd[d] = cyc;
      v = 8'hEE;
      if (d == 0) begin
        chk("pop_while_empty[0]", longint'(fifo_a.size() == 0), 0);
        if (fifo_a.size() > 0) v = fifo_a.pop_front();
        data_a = v;
      end else begin
        chk("pop_while_empty[1]", longint'(fifo_b.size() == 0), 0);
        if (fifo_b.size() > 0) v = fifo_b.pop_front();
        data_b = v;
      end
      hold[d] = 1'b1;
    end else if (hold[d]) begin
      hold[d] = 1'b0;
    end else begin
      if (d == 0) data_a = 8'($urandom);
      else        data_b = 8'($urandom);
    end
    prev_rd[d] = rd;
    if (d == 0) empty_a = (fifo_a.size() == 0);
    else        empty_b = (fifo_b.size() == 0);
  endtask

  // Line monitor: decodes one 8N1 frame per start bit and checks it against the scoreboard.
  task automatic mon_step(input int d);
    int cpb;
    logic t, dn;
    logic [7:0] exp_b;
    bit got;
    cpb = (d == 0) ? 4 : 2;
    t = get_tx(d);
    dn = get_done(d);
    if (dn) done_cnt[d]++;
    if (!rst_n) begin
      if (ph[d] != 0) begin
        if (d == 0 && sb_a.size() > 0) void'(sb_a.pop_front());
        if (d == 1 && sb_b.size() > 0) void'(sb_b.pop_front());
      end
      ph[d] = 0;
      return;
    end
    case (ph[d])
      0: if (!t) begin
        chk($sformatf("start_latency[%0d]", d), cyc - last_rd[d], 2);
        ph[d] = 1; k[d] = 1;
        e_start[d] = 0; e_bit[d] = 0; e_stop[d] = 0; e_done[d] = 0;
      end
      1: begin
        if (t) e_start[d] = 1;
        if (dn) e_done[d] = 1;
        k[d]++;
        if (k[d] == cpb) begin ph[d] = 2; k[d] = 0; bitn[d] = 0; end
      end
      2: begin
        if (k[d] == 0) acc[d][bitn[d]] = t;
        else if (t != acc[d][bitn[d]]) e_bit[d] = 1;
        if (dn) e_done[d] = 1;
        k[d]++;
        if (k[d] == cpb) begin
          k[d] = 0;
          bitn[d]++;
          if (bitn[d] == 8) ph[d] = 3;
        end
      end
      3: begin
        if (!t) e_stop[d] = 1;
        if (dn) e_done[d] = 1;
        k[d]++;
        if (k[d] == cpb) ph[d] = 4;
      end
      default: begin
        got = 0;
        exp_b = 8'h00;
        if (d == 0 && sb_a.size() > 0) begin exp_b = sb_a.pop_front(); got = 1; end
        if (d == 1 && sb_b.size() > 0) begin exp_b = sb_b.pop_front(); got = 1; end
        chk($sformatf("frame_expected[%0d]", d), longint'(got), 1);
        if (got) chk($sformatf("line_byte[%0d]", d), acc[d], exp_b);
        chk($sformatf("tx_done_after_stop[%0d]", d), longint'(dn), 1);
        chk($sformatf("start_bit_low[%0d]", d), longint'(e_start[d]), 0);
        chk($sformatf("data_bit_width[%0d]", d), longint'(e_bit[d]), 0);
        chk($sformatf("stop_bit_high[%0d]", d), longint'(e_stop[d]), 0);
        chk($sformatf("no_early_done[%0d]", d), longint'(e_done[d]), 0);
        ph[d] = 0;
      end
    endcase
  endtask

  always @(negedge rd_clk) begin
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      mon_step(d);
    end
  end

  task automatic wait_rd(input int d, input int lim, output int c);
    bit found;
    found = 0;
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge rd_clk);
      if (get_rd(d)) begin c = cyc; found = 1; break; end
    end
    chk($sformatf("rd_en_seen[%0d]", d), longint'(found), 1);
  endtask

  task automatic wait_done(input int d, input int lim, output int c);
    bit found;
    found = 0;
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge rd_clk);
      if (get_done(d)) begin c = cyc; found = 1; break; end
    end
    chk($sformatf("tx_done_seen[%0d]", d), longint'(found), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bad, r, p, e, c, c0, c1, c2;
    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    empty_a = 1'b1; empty_b = 1'b1;
    data_a = 8'h00; data_b = 8'h00;
    send(0, 8'h55);

    repeat (2) @(negedge rd_clk);
    bad = 0;
    repeat (10) begin
      @(negedge rd_clk);
      if (tx_a !== 1'b1 || rd_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      if (tx_b !== 1'b1 || rd_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) bad++;
    end
    chk("reset_hold_outputs", bad, 0);

    rst_n = 1'b1;
    r = cyc;
    wait_rd(0, 10, c);
    chk("first_pop_after_reset", c - r, 1);
    wait_done(0, 100, c2);

    repeat (5) @(negedge rd_clk);
    send(0, 8'h34);
    p = cyc;
    wait_rd(0, 10, c);
    chk("pop_latency", c - p, 1);
    wait_done(0, 100, c2);
    chk("single_done_cycle", c2 - c, 42);

    repeat (5) @(negedge rd_clk);
    send(0, 8'h34); send(0, 8'h28); send(0, 8'hAB);
    wait_rd(0, 10, c0);
    wait_rd(0, 100, c1);
    wait_rd(0, 100, c);
    chk("b2b_gap_1", c1 - c0, 43);
    chk("b2b_gap_2", c - c1, 43);
    wait_done(0, 100, c2);

    bad = 0;
    repeat (200) begin
      @(negedge rd_clk);
      if (rd_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    chk("empty_fifo_idle", bad, 0);

    send(0, 8'h28); send(0, 8'h77);
    wait_rd(0, 10, c);
    repeat (12) @(negedge rd_clk);
    en_a = 1'b0;
    wait_done(0, 100, c2);
    chk("drop_frame_done_cycle", c2 - c, 42);
    bad = 0;
    repeat (60) begin
      @(negedge rd_clk);
      if (rd_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    chk("no_pop_while_disabled", bad, 0);
    en_a = 1'b1;
    e = cyc;
    wait_rd(0, 10, c);
    chk("reenable_pop_latency", c - e, 1);
    wait_done(0, 100, c2);

    repeat (5) @(negedge rd_clk);
    send(0, 8'h5A);
    wait_rd(0, 10, c);
    repeat (10) @(negedge rd_clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", longint'(tx_a), 1);
    chk("async_reset_rd_en", longint'(rd_a), 0);
    chk("async_reset_busy", longint'(busy_a), 0);
    repeat (2) @(negedge rd_clk);
    send(0, 8'h66);
    bad = 0;
    repeat (10) begin
      @(negedge rd_clk);
      if (rd_a !== 1'b0 || tx_a !== 1'b1) bad++;
    end
    chk("no_pop_during_reset", bad, 0);
    rst_n = 1'b1;
    r = cyc;
    wait_rd(0, 10, c);
    chk("pop_after_midframe_reset", c - r, 1);
    wait_done(0, 100, c2);

    repeat (5) @(negedge rd_clk);
    send(1, 8'hFF); send(1, 8'h00);
    wait_rd(1, 10, c0);
    wait_rd(1, 60, c1);
    chk("cpb2_period", c1 - c0, 23);
    wait_done(1, 60, c2);
    chk("cpb2_done_cycle", c2 - c1, 22);

    repeat (5) @(negedge rd_clk);
    chk("scoreboard_a_drained", sb_a.size(), 0);
    chk("scoreboard_b_drained", sb_b.size(), 0);
    chk("fifo_a_drained", fifo_a.size(), 0);
    chk("done_count_a", done_cnt[0], 8);
    chk("pop_count_a", pop_cnt[0], 9);
    chk("done_count_b", done_cnt[1], 2);
    chk("pop_count_b", pop_cnt[1], 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
